// File: rtl/pipe_debug_display_pkg.sv
// Shared definitions for the pipeline debug display.
//   mode_e     : display mode encodings driven on the mode input
//   SEG_*      : active-low seven-segment patterns, bit0 = a .. bit6 = g
//   SEG_BLANK  : all segments off
package pipe_debug_display_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_SPLIT  = 2'd2,
        MODE_BLANK  = 2'd3
    } mode_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/pipe_debug_display_if.sv
// Signal bundle between a debug source and the display.
//   ch_data : flattened channels, channel k at [k*DATA_W +: DATA_W]
//   mode    : display mode (see mode_e)
//   sel     : channel index used in manual mode
//   freeze  : level input; every rising edge toggles the frozen state
//   hex     : active-low segments, digit d at [d*7 +: 7], digit 0 rightmost
//   ch_idx  : channel currently displayed (0 in split/blank)
//   frozen  : current freeze state
// All signals are plain levels sampled on the rising clock edge; there is
// no valid/ready handshake on this bundle.
interface pipe_debug_display_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 8
);
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [1:0]               mode;
    logic [3:0]               sel;
    logic                     freeze;
    logic [NUM_DIGITS*7-1:0]  hex;
    logic [3:0]               ch_idx;
    logic                     frozen;

    modport master (
        output ch_data, mode, sel, freeze,
        input  hex, ch_idx, frozen
    );

    modport slave (
        input  ch_data, mode, sel, freeze,
        output hex, ch_idx, frozen
    );
endinterface

// File: rtl/pipe_debug_display_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
//   nibble : 4-bit value 0..F
//   seg    : active-low segments, bit0 = a .. bit6 = g
module hex_to_seg
    import pipe_debug_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end
endmodule

// File: rtl/pipe_debug_display.sv
// Pipeline debug display: shows one of several debug words (e.g. PCs of
// each pipeline stage) on a row of seven-segment digits.
//   clk, rst : single clock, asynchronous active-high reset
//   bus      : pipe_debug_display_if slave (ch_data/mode/sel/freeze in,
//              hex/ch_idx/frozen out, all outputs registered)
// Modes: manual (sel picks channel), auto (channel rotates every
// DWELL_CYCLES clocks), split (low byte of channels 0.. on digit pairs),
// blank. A freeze toggle latches all channels into a snapshot.
module pipe_debug_display
    import pipe_debug_display_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DATA_W       = 32,
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input logic                 clk,
    input logic                 rst,
    pipe_debug_display_if.slave bus
);
    localparam int              CNT_W    = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [4:0]      NUM_CH_5 = 5'(NUM_CH);

    // State
    logic [NUM_CH*DATA_W-1:0] snapshot;
    logic                     freeze_q;
    logic                     frozen_q;
    mode_e                    mode_q;
    logic [CNT_W-1:0]         cnt;
    logic [3:0]               idx_q;
    logic [NUM_DIGITS*7-1:0]  hex_q;

    // Next-state values
    mode_e                    mode_cur;
    logic                     freeze_rise;
    logic                     frozen_next;
    logic [NUM_CH*DATA_W-1:0] snapshot_next;
    logic [NUM_CH*DATA_W-1:0] src_data;
    logic [CNT_W-1:0]         cnt_next;
    logic [3:0]               idx_next;
    logic                     idx_in_range;
    logic [31:0]              ch_w [16];
    logic [31:0]              disp_word;
    logic [NUM_DIGITS*7-1:0]  hex_next;

    assign mode_cur    = mode_e'(bus.mode);
    assign freeze_rise = bus.freeze & ~freeze_q;
    assign frozen_next = frozen_q ^ freeze_rise;

    // Snapshot is captured only on the edge that enters the frozen state.
    assign snapshot_next = (freeze_rise && !frozen_q) ? bus.ch_data : snapshot;

    // Display source follows the freeze state being entered this edge, so
    // hex and frozen always describe the same data.
    assign src_data = frozen_next ? snapshot_next : bus.ch_data;

    // Channels zero-extended to 32 bits; unused slots read as zero so that
    // any 4-bit index can be looked up safely.
    for (genvar k = 0; k < 16; k++) begin : g_ch
        if (k < NUM_CH) begin : g_used
            assign ch_w[k] = 32'(src_data[k*DATA_W +: DATA_W]);
        end else begin : g_unused
            assign ch_w[k] = 32'h0;
        end
    end

    // Channel index and dwell counter
    always_comb begin
        idx_next = idx_q;
        cnt_next = cnt;
        unique case (mode_cur)
            MODE_MANUAL: begin
                idx_next = bus.sel;
                cnt_next = '0;
            end
            MODE_AUTO: begin
                if (mode_q != MODE_AUTO) begin
                    idx_next = '0;
                    cnt_next = '0;
                end else if (!frozen_q) begin
                    if (cnt == CNT_LAST) begin
                        cnt_next = '0;
                        idx_next = ({1'b0, idx_q} >= NUM_CH_5 - 5'd1) ? 4'd0 : idx_q + 4'd1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                idx_next = '0;
                cnt_next = '0;
            end
        endcase
    end

    assign idx_in_range = {1'b0, idx_next} < NUM_CH_5;
    assign disp_word    = ch_w[idx_next];

    // Per-digit nibble selection and decode
    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        // Split mode: digit pair counted from the left holds channel K.
        localparam int K = NUM_DIGITS / 2 - 1 - d / 2;

        logic [3:0] nib;
        logic       blank;
        logic [6:0] seg;

        always_comb begin
            nib   = 4'h0;
            blank = 1'b1;
            unique case (mode_cur)
                MODE_MANUAL, MODE_AUTO: begin
                    nib   = disp_word[d*4 +: 4];
                    blank = !idx_in_range;
                end
                MODE_SPLIT: begin
                    if (K < NUM_CH) begin
                        nib   = (d % 2 == 1) ? ch_w[K][7:4] : ch_w[K][3:0];
                        blank = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        hex_to_seg u_seg (
            .nibble (nib),
            .seg    (seg)
        );

        assign hex_next[d*7 +: 7] = blank ? SEG_BLANK : seg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_q    <= {NUM_DIGITS{SEG_BLANK}};
            idx_q    <= '0;
            frozen_q <= 1'b0;
            freeze_q <= 1'b0;
            cnt      <= '0;
            snapshot <= '0;
            mode_q   <= MODE_MANUAL;
        end else begin
            hex_q    <= hex_next;
            idx_q    <= idx_next;
            frozen_q <= frozen_next;
            freeze_q <= bus.freeze;
            cnt      <= cnt_next;
            snapshot <= snapshot_next;
            mode_q   <= mode_cur;
        end
    end

    assign bus.hex    = hex_q;
    assign bus.ch_idx = idx_q;
    assign bus.frozen = frozen_q;

endmodule

// File: tb/tb_pipe_debug_display.sv
// Directed bench for pipe_debug_display: a 4-channel instance plus a
// 3-channel instance sharing the same stimulus (for the split blanking case).
module tb_pipe_debug_display;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_debug_display_if #(.NUM_CH(4), .DATA_W(32), .NUM_DIGITS(8)) bus  ();
    pipe_debug_display_if #(.NUM_CH(3), .DATA_W(32), .NUM_DIGITS(8)) bus3 ();

    assign bus3.ch_data = bus.ch_data[95:0];
    assign bus3.mode    = bus.mode;
    assign bus3.sel     = bus.sel;
    assign bus3.freeze  = bus.freeze;

    pipe_debug_display #(
        .NUM_CH(4), .DATA_W(32), .NUM_DIGITS(8), .DWELL_CYCLES(4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    pipe_debug_display #(
        .NUM_CH(3), .DATA_W(32), .NUM_DIGITS(8), .DWELL_CYCLES(4)
    ) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] rep8(input logic [6:0] s);
        return {8{s}};
    endfunction

    initial begin
        rst         = 1'b1;
        bus.ch_data = '0;
        bus.mode    = 2'd0;
        bus.sel     = 4'd0;
        bus.freeze  = 1'b0;

        // Reset values
        #1;
        check("reset_hex", bus.hex, rep8(7'h7F));
        check("reset_idx", bus.ch_idx, 4'd0);
        check("reset_frozen", bus.frozen, 1'b0);
        check("reset_hex_ch3", bus3.hex, rep8(7'h7F));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Manual, all-zero channel 0
        step();
        check("man_zero", bus.hex, rep8(7'h40));

        // Manual sel=1, result appears exactly one edge later
        bus.ch_data = {32'h0, 32'h0, 32'h0040_00AF, 32'h0};
        bus.sel     = 4'd1;
        #1;
        check("man_no_early", bus.hex, rep8(7'h40));
        step();
        check("man_sel1", bus.hex, {7'h40, 7'h40, 7'h19, 7'h40, 7'h40, 7'h40, 7'h08, 7'h0E});
        check("man_sel1_idx", bus.ch_idx, 4'd1);

        // Out-of-range select blanks
        bus.sel = 4'd5;
        step();
        check("man_sel5", bus.hex, rep8(7'h7F));
        check("man_sel5_idx", bus.ch_idx, 4'd5);

        // Full encoding coverage across channels 0 and 2
        bus.ch_data = {32'h0, 32'h0123_4567, 32'h0, 32'h89AB_CDEF};
        bus.sel     = 4'd0;
        step();
        check("man_89ab", bus.hex, {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E});
        bus.sel = 4'd2;
        step();
        check("man_0123", bus.hex, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78});

        // Split: low bytes only, 3-channel build blanks the last pair
        bus.ch_data = {32'hFFFF_FF78, 32'hABCD_EF56, 32'h9999_9934, 32'h7777_7712};
        bus.mode    = 2'd2;
        step();
        check("split_hex", bus.hex, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});
        check("split_idx", bus.ch_idx, 4'd0);
        check("split_hex_ch3", bus3.hex, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h7F, 7'h7F});

        // Blank mode
        bus.mode = 2'd3;
        step();
        check("blank_hex", bus.hex, rep8(7'h7F));
        check("blank_idx", bus.ch_idx, 4'd0);

        // Auto: four cycles per channel, wrap 3 -> 0
        bus.ch_data = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        bus.mode    = 2'd1;
        for (int i = 0; i <= 16; i++) begin
            step();
            check($sformatf("auto_idx_%0d", i), bus.ch_idx, 4'((i / 4) % 4));
            if (i == 0)  check("auto_hex_a", bus.hex, rep8(7'h08));
            if (i == 4)  check("auto_hex_b", bus.hex, rep8(7'h03));
            if (i == 8)  check("auto_hex_c", bus.hex, rep8(7'h46));
            if (i == 12) check("auto_hex_d", bus.hex, rep8(7'h21));
        end

        // Freeze mid-dwell: counter holds, display holds snapshot
        step();
        bus.freeze = 1'b1;
        step();
        check("auto_frz_on", bus.frozen, 1'b1);
        check("auto_frz_idx", bus.ch_idx, 4'd0);
        bus.freeze  = 1'b0;
        bus.ch_data = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'h5555_5555};
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("auto_hold_idx_%0d", i), bus.ch_idx, 4'd0);
            check($sformatf("auto_hold_hex_%0d", i), bus.hex, rep8(7'h08));
        end
        bus.freeze = 1'b1;
        step();
        check("auto_frz_off", bus.frozen, 1'b0);
        check("auto_live_hex", bus.hex, rep8(7'h12));
        check("auto_resume_idx0", bus.ch_idx, 4'd0);
        bus.freeze = 1'b0;
        step();
        check("auto_resume_idx1", bus.ch_idx, 4'd0);
        step();
        check("auto_resume_idx2", bus.ch_idx, 4'd1);
        check("auto_resume_hex", bus.hex, rep8(7'h03));

        // Manual freeze
        bus.mode    = 2'd0;
        bus.sel     = 4'd0;
        bus.ch_data = {32'h0, 32'h0, 32'h0, 32'h1111_1111};
        step();
        check("frz_pre_hex", bus.hex, rep8(7'h79));
        check("frz_pre", bus.frozen, 1'b0);
        bus.freeze = 1'b1;
        step();
        check("frz_on", bus.frozen, 1'b1);
        bus.freeze  = 1'b0;
        bus.ch_data = {32'h0, 32'h0, 32'h0, 32'h2222_2222};
        step();
        check("frz_hold_hex", bus.hex, rep8(7'h79));
        check("frz_hold", bus.frozen, 1'b1);
        step();
        check("frz_hold_hex2", bus.hex, rep8(7'h79));
        bus.freeze = 1'b1;
        step();
        check("frz_off", bus.frozen, 1'b0);
        check("frz_off_hex", bus.hex, rep8(7'h24));
        bus.freeze = 1'b0;
        step();

        // Freeze edge together with a mode change
        bus.freeze = 1'b1;
        bus.mode   = 2'd3;
        step();
        check("frz_mode_frozen", bus.frozen, 1'b1);
        check("frz_mode_hex", bus.hex, rep8(7'h7F));
        bus.freeze  = 1'b0;
        bus.mode    = 2'd0;
        bus.ch_data = {32'h0, 32'h0, 32'h0, 32'h3333_3333};
        step();
        check("frz_mode_snap", bus.hex, rep8(7'h24));
        bus.freeze = 1'b1;
        step();
        check("frz_mode_off", bus.frozen, 1'b0);
        check("frz_mode_live", bus.hex, rep8(7'h30));
        bus.freeze = 1'b0;

        // Asynchronous reset mid-dwell while frozen
        bus.mode = 2'd1;
        step(2);
        bus.freeze = 1'b1;
        step();
        check("pre_rst_frozen", bus.frozen, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_hex", bus.hex, rep8(7'h7F));
        check("async_rst_idx", bus.ch_idx, 4'd0);
        check("async_rst_frozen", bus.frozen, 1'b0);
        bus.freeze = 1'b0;
        #2;
        rst = 1'b0;
        step();
        check("post_rst_frozen", bus.frozen, 1'b0);
        check("post_rst_hex", bus.hex, rep8(7'h30));
        check("post_rst_idx", bus.ch_idx, 4'd0);
        step(3);
        check("post_rst_idx3", bus.ch_idx, 4'd0);
        step();
        check("post_rst_idx4", bus.ch_idx, 4'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_debug_display.md
PIPE_DEBUG_DISPLAY -- requirements
Module: pipe_debug_display

Interface
REQ-001 Parameter NUM_CH, default 4, number of 32-bit-max debug channels (e.g. PC_IF/PC_ID/PC_EXE/PC_MEM), range 1..16.
REQ-002 Parameter DATA_W, default 32, width of each channel, range 4..32.
REQ-003 Parameter NUM_DIGITS, default 8, number of seven-segment digits driven, even, range 2..8.
REQ-004 Parameter DWELL_CYCLES, default 50_000_000, clk cycles per channel in auto mode, minimum 2.
REQ-005 clk  input  1  single clock; one clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 ch_data  input  NUM_CH*DATA_W  flattened channels, channel k at bits [k*DATA_W +: DATA_W].
REQ-008 mode  input  2  0 manual, 1 auto-cycle, 2 split, 3 blank.
REQ-009 sel  input  4  channel index in manual mode.
REQ-010 freeze  input  1  synchronous level; each rising edge toggles freeze state.
REQ-011 hex  output  NUM_DIGITS*7  active-low segments, digit d at [d*7 +: 7], bit0=a..bit6=g, digit 0 rightmost.
REQ-012 ch_idx  output  4  channel currently displayed (manual/auto); 0 in split/blank.
REQ-013 frozen  output  1  freeze state.

Function
REQ-014 Encoding SHALL be: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E, blank=0x7F.
REQ-015 hex, ch_idx, frozen SHALL be registered; a change on ch_data/mode/sel SHALL appear on hex exactly 1 cycle later (unfrozen).
REQ-016 Freeze edge detection SHALL use a registered copy of freeze; on rising edge frozen toggles; entering frozen captures all ch_data into a snapshot register the same edge.
REQ-017 While frozen=1 hex SHALL be derived from the snapshot; while frozen=0 from live ch_data.
REQ-018 Manual: digit d shows nibble d of channel sel, zero-extended above DATA_W; sel>=NUM_CH SHALL blank all digits and set ch_idx=sel.
REQ-019 Auto: dwell counter counts 0..DWELL_CYCLES-1; on terminal count ch_idx increments, wrapping NUM_CH-1 -> 0; display per REQ-018 using ch_idx.
REQ-020 Entering auto (mode becomes 1 from any other value) SHALL reset ch_idx to 0 and counter to 0 on that edge.
REQ-021 Split: channel k (k < NUM_DIGITS/2) shows its low byte on digits NUM_DIGITS-1-2k (high nibble) and NUM_DIGITS-2-2k (low nibble); digit pairs with k>=NUM_CH blank; channels k>=NUM_DIGITS/2 not shown.
REQ-022 Mode 3 SHALL blank all digits; counter held at 0.
REQ-023 Freeze edge and mode change in the same cycle SHALL both take effect; freeze state is independent of mode.
REQ-024 Dwell counter SHALL hold at 0 outside auto mode and not advance while frozen.

Reset
REQ-025 During rst: hex all 0x7F, ch_idx 0, frozen 0, counter 0, snapshot 0, freeze edge register 0.
REQ-026 Reset mid-dwell or mid-freeze SHALL abandon state; first post-reset cycle behaves as power-up with current inputs.

Structure
REQ-027 Shared package SHALL hold mode encodings (MODE_MANUAL/AUTO/SPLIT/BLANK), SEG_BLANK constant and segment constants.
REQ-028 One combinational sub-module hex_to_seg (4-bit nibble -> 7-bit active-low) SHALL be instantiated per digit; all sequential logic in pipe_debug_display.

Verification
REQ-029 Bench with NUM_CH=4, DATA_W=32, NUM_DIGITS=8, DWELL_CYCLES=4.
REQ-030 Reset: assert rst mid-run -> hex=0x7F all digits, ch_idx=0, frozen=0 asynchronously.
REQ-031 Manual: ch1=0x0040_00AF, sel=1 -> one cycle later digits7..0 = 0x40,0x40,0x19,0x40,0x40,0x40,0x08,0x0E; sel=5 -> all 0x7F, ch_idx=5.
REQ-032 Auto: mode 0->1 -> ch_idx 0 for 4 cycles, then 1,2,3, then 0 (wrap); with freeze high counter holds.
REQ-033 Split: ch0..3 low bytes 0x12,0x34,0x56,0x78 -> digits7..0 show 1,2,3,4,5,6,7,8; NUM_CH=3 build -> digits1,0 blank.
REQ-034 Freeze: ch0=0x1111_1111, pulse freeze, change ch0=0x2222_2222 -> hex still shows 1s, frozen=1; second pulse -> 2s after 1 cycle, frozen=0.
